// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole playfield: hole state encoding,
// spawner LFSR geometry and its step function.
package mole_pkg;

  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HIT  = 2'd2,
    MISS = 2'd3
  } hole_state_e;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_hole.sv
// One playfield hole: raises a mole on spawn, counts down its up-time in
// game ticks, and resolves to HIT (strike) or MISS (expiry) for one cycle.
module mole_hole
  import mole_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frozen_i,
  input  logic             kill_i,
  input  logic             tick_i,
  input  logic             spawn_i,
  input  logic             strike_i,
  input  logic [CNT_W-1:0] up_ticks_i,
  output logic             out_o,
  output logic             fail_o,
  output logic             hit_pulse_o,
  output logic             miss_pulse_o
);

  hole_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fail_q, fail_d;
  logic             last_tick;

  assign last_tick = (cnt_q <= CNT_W'(1));

  // State, countdown and sticky fail flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  // Next state: game over forces IDLE; otherwise advance only when not frozen.
  // A strike is checked before expiry so a hit on the last tick still counts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    if (kill_i) begin
      state_d = IDLE;
    end else if (!frozen_i) begin
      case (state_q)
        IDLE: if (spawn_i) begin
          state_d = UP;
          cnt_d   = up_ticks_i;
          fail_d  = 1'b0;
        end
        UP: begin
          if (strike_i) begin
            state_d = HIT;
          end else if (tick_i) begin
            if (last_tick) begin
              state_d = MISS;
              fail_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        HIT, MISS: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs: visible mole, sticky fail, and one-cycle event pulses for counters.
  always_comb begin
    out_o        = (state_q == UP) && !kill_i;
    fail_o       = fail_q;
    hit_pulse_o  = (state_q == UP) && !kill_i && !frozen_i && strike_i;
    miss_pulse_o = (state_q == UP) && !kill_i && !frozen_i && !strike_i &&
                   tick_i && last_tick;
  end

endmodule

// File: rtl/mole_field.sv
// Whack-a-mole playfield: shared tick prescaler and LFSR spawner, one
// mole_hole per switch, saturating score/miss counters and game-over latch.
// Optional MOLE_ESCALATE_EN shortens mole up-time by one tick per 8 hits.
module mole_field
  import mole_pkg::*;
#(
  parameter int              N_HOLES   = 10,
  parameter int              TICK_DIV  = 25000000,
  parameter int              UP_TICKS  = 3,
  parameter int              MAX_MISS  = 3,
  parameter int              SCORE_W   = 8,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          keep,
  input  logic [N_HOLES-1:0]            sw,
  output logic [N_HOLES-1:0]            out,
  output logic [N_HOLES-1:0]            fail,
  output logic [SCORE_W-1:0]            score,
  output logic [$clog2(MAX_MISS+1)-1:0] misses,
  output logic                          game_over
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W   = $clog2(UP_TICKS + 1);
  localparam int MISS_W  = $clog2(MAX_MISS + 1);
  localparam int CW      = $clog2(N_HOLES + 1);
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

  logic [N_HOLES-1:0] sw_q;
  logic [PRESC_W-1:0] presc_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic               game_over_q, game_over_d;

  logic               frozen, tick;
  logic [N_HOLES-1:0] strike, spawn, hit_pulse, miss_pulse;
  logic [CW-1:0]      hit_cnt, miss_cnt;
  logic [CNT_W-1:0]   up_ticks;

  assign frozen = keep | game_over_q;
  assign tick   = !frozen && (presc_q == PRESC_W'(TICK_DIV - 1));
  assign strike = sw & ~sw_q & {N_HOLES{~frozen}};

`ifdef MOLE_ESCALATE_EN
  logic [31:0] level;
  assign level = 32'(score_q >> 3);
  // Up-time shrinks by one tick per 8 hits, never below one tick.
  always_comb begin
    up_ticks = CNT_W'(1);
    if (level + 32'd1 < 32'(UP_TICKS)) up_ticks = CNT_W'(32'(UP_TICKS) - level);
  end
`else
  assign up_ticks = CNT_W'(UP_TICKS);
`endif

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    // The LFSR picks at most one hole per tick; indices >= N_HOLES spawn nothing.
    assign spawn[g] = tick && (lfsr_q[3:0] == 4'(g));

    mole_hole #(.CNT_W(CNT_W)) u_hole (
      .clk          (clk),
      .rst          (rst),
      .frozen_i     (frozen),
      .kill_i       (game_over_q),
      .tick_i       (tick),
      .spawn_i      (spawn[g]),
      .strike_i     (strike[g]),
      .up_ticks_i   (up_ticks),
      .out_o        (out[g]),
      .fail_o       (fail[g]),
      .hit_pulse_o  (hit_pulse[g]),
      .miss_pulse_o (miss_pulse[g])
    );
  end

  // Count simultaneous hits/misses and apply saturating counter updates.
  always_comb begin
    logic [31:0] s_sum, m_sum;
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      hit_cnt  = hit_cnt + CW'(hit_pulse[i]);
      miss_cnt = miss_cnt + CW'(miss_pulse[i]);
    end
    s_sum = 32'(score_q) + 32'(hit_cnt);
    m_sum = 32'(misses_q) + 32'(miss_cnt);
    score_d  = (s_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(s_sum);
    misses_d = (m_sum > 32'(MAX_MISS)) ? MISS_W'(MAX_MISS) : MISS_W'(m_sum);
    game_over_d = game_over_q || (misses_q == MISS_W'(MAX_MISS));
  end

  // Global state: switch history always samples; the game itself holds while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q        <= sw;
      presc_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      sw_q        <= sw;
      game_over_q <= game_over_d;
      if (!frozen) begin
        presc_q  <= tick ? '0 : presc_q + 1'b1;
        lfsr_q   <= lfsr_next(lfsr_q);
        score_q  <= score_d;
        misses_q <= misses_d;
      end
    end
  end

  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_field.sv
// Self-checking bench for mole_field: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the game rules.
module tb_mole_field;

  localparam int N   = 10;
  localparam int DIV = 4;
  localparam int UPT = 3;
  localparam int MM  = 3;
  localparam int SW  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         keep = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] out, fail;
  logic [SW-1:0] score;
  logic [1:0]   misses;
  logic         game_over;

  int tests_run = 0;
  int tests_failed = 0;

  mole_field #(
    .N_HOLES(N), .TICK_DIV(DIV), .UP_TICKS(UPT), .MAX_MISS(MM),
    .SCORE_W(SW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .keep(keep), .sw(sw), .out(out), .fail(fail),
    .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [15:0]    m_lfsr;
  int           m_presc;
  bit           m_up   [N];
  bit           m_busy [N];
  int           m_rem  [N];
  bit           m_fail [N];
  int           m_score, m_miss;
  bit           m_go;
  bit [N-1:0]   m_swq;

  function automatic int uptime();
`ifdef MOLE_ESCALATE_EN
    int u;
    u = UPT - (m_score / 8);
    return (u < 1) ? 1 : u;
`else
    return UPT;
`endif
  endfunction

  function automatic logic [N-1:0] m_outv();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_up[i] && !m_go;
    return r;
  endfunction

  function automatic logic [N-1:0] m_failv();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_fail[i];
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] s, input logic k, input logic r);
    bit frz, tk, go_next, strike;
    int idx, nh, nm, ut;
    if (r) begin
      m_lfsr = 16'hACE1; m_presc = 0; m_score = 0; m_miss = 0; m_go = 0;
      for (int i = 0; i < N; i++) begin
        m_up[i] = 0; m_busy[i] = 0; m_rem[i] = 0; m_fail[i] = 0;
      end
      m_swq = s;
      return;
    end
    frz     = k || m_go;
    go_next = m_go || (m_miss == MM);
    if (m_go) begin
      for (int i = 0; i < N; i++) begin m_up[i] = 0; m_busy[i] = 0; end
    end else if (!frz) begin
      tk  = (m_presc == DIV - 1);
      idx = int'(m_lfsr % 16);
      ut  = uptime();
      nh = 0; nm = 0;
      for (int i = 0; i < N; i++) begin
        strike = s[i] && !m_swq[i];
        if (m_up[i]) begin
          if (strike) begin
            m_up[i] = 0; m_busy[i] = 1; nh++;
          end else if (tk) begin
            if (m_rem[i] == 1) begin
              m_up[i] = 0; m_busy[i] = 1; m_fail[i] = 1; nm++;
            end else m_rem[i]--;
          end
        end else if (m_busy[i]) begin
          m_busy[i] = 0;
        end else if (tk && idx == i) begin
          m_up[i] = 1; m_rem[i] = ut; m_fail[i] = 0;
        end
      end
      m_score = (m_score + nh > 255) ? 255 : m_score + nh;
      m_miss  = (m_miss + nm > MM) ? MM : m_miss + nm;
      m_presc = tk ? 0 : m_presc + 1;
      m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    m_go  = go_next;
    m_swq = s;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle after it.
  task automatic step(input logic [N-1:0] s, input logic k, input logic r);
    @(negedge clk);
    sw = s; keep = k; rst = r;
    @(posedge clk);
    model_step(s, k, r);
    #1;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1);
  endtask

  // Step with idle switches until the model shows a freshly raised mole.
  task automatic run_until_rise(output int k, output bit ok);
    logic [N-1:0] prev, cur;
    ok = 0; k = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      prev = m_outv();
      step('0, 1'b0, 1'b0);
      cur = m_outv();
      for (int i = 0; i < N; i++)
        if (cur[i] && !prev[i] && !ok) begin k = i; ok = 1; end
    end
    if (!ok) begin
      tests_run++; tests_failed++;
      $display("FAIL spawn_timeout: no mole within 500 cycles");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [N-1:0] s2;
    s2 = '0; s2[2] = 1'b1;
    step(s2, 1'b0, 1'b1);
    step(s2, 1'b0, 1'b1);
    tests_run++;
    if ({out, fail, score, misses, game_over} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got out=%h fail=%h score=%0d misses=%0d go=%b exp all 0",
               out, fail, score, misses, game_over);
    end
    tests_run++;
    if (dut.lfsr_q !== 16'hACE1) begin
      tests_failed++; $display("FAIL reset_lfsr: got %h exp ace1", dut.lfsr_q);
    end
    step(s2, 1'b0, 1'b0);
    tests_run++;
    if (score !== 8'd0 || out !== '0) begin
      tests_failed++; $display("FAIL reset_held_sw: got score=%0d out=%h exp 0/0", score, out);
    end
    tests_run++;
    if (dut.lfsr_q !== m_lfsr) begin
      tests_failed++; $display("FAIL lfsr_step: got %h exp %h", dut.lfsr_q, m_lfsr);
    end
  endtask

  task automatic test_hit();
    int k; bit ok;
    logic [N-1:0] s;
    do_reset();
    run_until_rise(k, ok);
    if (!ok) return;
    repeat (4) step('0, 1'b0, 1'b0);
    tests_run++;
    if (out[k] !== 1'b1) begin
      tests_failed++; $display("FAIL hit_still_up: got %b exp 1", out[k]);
    end
    s = '0; s[k] = 1'b1;
    step(s, 1'b0, 1'b0);
    tests_run++;
    if (out[k] !== 1'b0 || score !== 8'd1 || fail[k] !== 1'b0 || misses !== 2'd0) begin
      tests_failed++;
      $display("FAIL hit_result: got out=%b score=%0d fail=%b misses=%0d exp 0/1/0/0",
               out[k], score, fail[k], misses);
    end
    step('0, 1'b0, 1'b0);
  endtask

  task automatic test_miss();
    int k, hi; bit ok;
    do_reset();
    run_until_rise(k, ok);
    if (!ok) return;
    hi = 0;
    while (out[k] && hi < 64) begin hi++; step('0, 1'b0, 1'b0); end
    tests_run++;
    if (hi !== 12) begin
      tests_failed++; $display("FAIL miss_uptime: got %0d cycles exp 12", hi);
    end
    tests_run++;
    if (fail[k] !== 1'b1 || misses !== 2'd1 || score !== 8'd0) begin
      tests_failed++;
      $display("FAIL miss_result: got fail=%b misses=%0d score=%0d exp 1/1/0", fail[k], misses, score);
    end
  endtask

  task automatic test_game_over();
    int c;
    do_reset();
    c = 0;
    while (!game_over && c < 3000) begin c++; step('0, 1'b0, 1'b0); end
    tests_run++;
    if (game_over !== 1'b1 || misses !== 2'd3 || out !== '0) begin
      tests_failed++;
      $display("FAIL game_over_set: got go=%b misses=%0d out=%h exp 1/3/0", game_over, misses, out);
    end
    for (int i = 0; i < 30; i++) step((i % 2) ? '1 : '0, 1'b0, 1'b0);
    tests_run++;
    if (score !== 8'd0 || out !== '0 || misses !== 2'd3 || game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL game_over_hold: got score=%0d out=%h misses=%0d go=%b exp 0/0/3/1",
               score, out, misses, game_over);
    end
    tests_run++;
    if (dut.lfsr_q !== m_lfsr) begin
      tests_failed++; $display("FAIL game_over_lfsr: got %h exp %h", dut.lfsr_q, m_lfsr);
    end
    do_reset();
    tests_run++;
    if ({out, fail, score, misses, game_over} !== '0) begin
      tests_failed++;
      $display("FAIL game_over_clear: got out=%h fail=%h score=%0d misses=%0d go=%b exp 0",
               out, fail, score, misses, game_over);
    end
  endtask

  task automatic test_keep();
    int k, hi; bit ok;
    logic [15:0] lf; int pr;
    logic [N-1:0] s;
    do_reset();
    run_until_rise(k, ok);
    if (!ok) return;
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    lf = m_lfsr; pr = m_presc;
    s = '0; s[k] = 1'b1;
    repeat (5)  step('0, 1'b1, 1'b0);
    repeat (5)  step(s,  1'b1, 1'b0);
    repeat (10) step('0, 1'b1, 1'b0);
    tests_run++;
    if (out[k] !== 1'b1 || score !== 8'd0) begin
      tests_failed++; $display("FAIL keep_strike: got out=%b score=%0d exp 1/0", out[k], score);
    end
    tests_run++;
    if (dut.lfsr_q !== lf || 32'(dut.presc_q) !== pr) begin
      tests_failed++;
      $display("FAIL keep_frozen: got lfsr=%h presc=%0d exp %h/%0d", dut.lfsr_q, dut.presc_q, lf, pr);
    end
    hi = 0;
    while (out[k] && hi < 64) begin hi++; step('0, 1'b0, 1'b0); end
    tests_run++;
    if (hi !== 10) begin
      tests_failed++; $display("FAIL keep_remaining: got %0d cycles exp 10", hi);
    end
  endtask

  task automatic test_expiry_hit();
    int k; bit ok;
    logic [N-1:0] s;
    do_reset();
    run_until_rise(k, ok);
    if (!ok) return;
    repeat (11) step('0, 1'b0, 1'b0);
    tests_run++;
    if (out[k] !== 1'b1) begin
      tests_failed++; $display("FAIL expiry_up: got %b exp 1", out[k]);
    end
    s = '0; s[k] = 1'b1;
    step(s, 1'b0, 1'b0);
    tests_run++;
    if (out[k] !== 1'b0 || score !== 8'd1 || misses !== 2'd0 || fail[k] !== 1'b0) begin
      tests_failed++;
      $display("FAIL expiry_hit: got out=%b score=%0d misses=%0d fail=%b exp 0/1/0/0",
               out[k], score, misses, fail[k]);
    end
  endtask

`ifdef MOLE_ESCALATE_EN
  task automatic test_escalate();
    int k, hi, c; bit ok;
    do_reset();
    c = 0;
    while (m_score < 16 && !m_go && c < 6000) begin
      c++;
      step(m_outv(), 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
    end
    tests_run++;
    if (score < 8'd16) begin
      tests_failed++; $display("FAIL escalate_score: got %0d exp >=16", score);
      return;
    end
    run_until_rise(k, ok);
    if (!ok) return;
    hi = 0;
    while (out[k] && hi < 64) begin hi++; step('0, 1'b0, 1'b0); end
    tests_run++;
    if (hi !== 4) begin
      tests_failed++; $display("FAIL escalate_uptime: got %0d cycles exp 4", hi);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] s;
    logic k, r;
    int bad;
    do_reset();
    s = '0; bad = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) s[i] = ~s[i];
      k = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(s, k, r);
      tests_run++;
      if ({out, fail, score, misses, game_over} !==
          {m_outv(), m_failv(), SW'(m_score), 2'(m_miss), m_go}) begin
        tests_failed++;
        if (bad < 10)
          $display("FAIL random_cycle%0d: got out=%h fail=%h score=%0d misses=%0d go=%b exp %h %h %0d %0d %b",
                   c, out, fail, score, misses, game_over,
                   m_outv(), m_failv(), m_score, m_miss, m_go);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_game_over();
    test_keep();
    test_expiry_hit();
`ifdef MOLE_ESCALATE_EN
    test_escalate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
